imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the decode stage; successor to the combinational immediate generator.
- Covers all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount) at parametrised XLEN.
- Flags unsupported opcodes and sustains 1 instruction/cycle under output backpressure, using a 2-entry skid buffer.
- Sits between instruction fetch/IR and the register-read/ALU-operand mux.

---
 rtl/imm_gen_pkg.sv | 40 ++++
 rtl/imm_gen_pipe_if.sv | 30 +++
 rtl/imm_decode_comb.sv | 64 ++++++
 rtl/imm_gen_pipe.sv | 92 +++++++++
 tb/tb_imm_gen_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and constants for the registered immediate generator.
//   imm_fmt_e  - immediate format tag driven on the fmt output
//   OPC_*      - RV32I/RV64I major opcodes that carry an immediate
//   F3_*       - OP-IMM funct3 values that need special handling
//   imm_res_t  - decoder result; imm is held at the widest XLEN (64) and
//                narrowed by the consumer
package imm_gen_pkg;

    localparam int unsigned IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SRx   = 3'b101;
    localparam logic [2:0] F3_SLTIU = 3'b011;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
    } imm_res_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: input (instruction) and output (immediate) handshakes of
// imm_gen_pipe bundled in one interface.
//   in_valid/in_ready/inst                   - instruction side
//   out_valid/out_ready/imm_val/fmt/illegal  - result side
//   modport slave  - the immediate generator
//   modport master - the surrounding pipeline (fetch/IR and operand mux)
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_val;
    imm_fmt_e        fmt;
    logic            illegal;

    modport master (
        output in_valid, inst, out_ready,
        input  in_ready, out_valid, imm_val, fmt, illegal
    );

    modport slave (
        input  in_valid, inst, out_ready,
        output in_ready, out_valid, imm_val, fmt, illegal
    );
endinterface

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: purely combinational instruction -> immediate decoder.
//   inst - raw 32-bit instruction word
//   res  - immediate (sign/zero extended to 64 bits), format tag, illegal flag
// Every path assigns every field, so no storage is inferred.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0] inst,
    output imm_res_t    res
);
    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0] opc;
    logic [2:0] f3;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];

    always_comb begin
        res.imm     = '0;
        res.fmt     = FMT_NONE;
        res.illegal = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                res.imm = {{(IMM_MAX_W-12){inst[31]}}, inst[31:20]};
                res.fmt = FMT_I;
            end
            OPC_OP_IMM: begin
                // Shifts carry only a shift amount; funct7 bits above it are ignored.
                // SLTIU (F3_SLTIU) keeps the ordinary sign-extended I immediate.
                if (f3 == F3_SLL || f3 == F3_SRx) begin
                    res.imm = {{(IMM_MAX_W-SHAMT_W){1'b0}}, inst[20 +: SHAMT_W]};
                    res.fmt = FMT_SHAMT;
                end else begin
                    res.imm = {{(IMM_MAX_W-12){inst[31]}}, inst[31:20]};
                    res.fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                res.imm = {{(IMM_MAX_W-12){inst[31]}}, inst[31:25], inst[11:7]};
                res.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                res.imm = {{(IMM_MAX_W-13){inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
                res.fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                res.imm = {{(IMM_MAX_W-32){inst[31]}}, inst[31:12], 12'b0};
                res.fmt = FMT_U;
            end
            OPC_JAL: begin
                res.imm = {{(IMM_MAX_W-21){inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
                res.fmt = FMT_J;
            end
            default: begin
                res.illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, handshaked immediate generator for decode.
//   clk, rst_n       - core clock, asynchronous active-low reset
//   bus (slave)      - in_valid/in_ready/inst in, out_valid/out_ready/
//                      imm_val/fmt/illegal out
//   stat_clr, stat_illegal_cnt - only when IMM_GEN_PIPE_STATS_EN is defined:
//                      saturating count of illegal results handed downstream
// Storage is an output register (OUT) plus one skid register (SKID), giving
// 1 inst/cycle with in_ready driven purely from a flop.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imm_gen_pipe_if.slave        bus
`ifdef IMM_GEN_PIPE_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [15:0]          stat_illegal_cnt
`endif
);
    imm_res_t dec;
    imm_res_t out_r;
    imm_res_t skid_r;
    logic     out_v;
    logic     skid_v;
    logic     in_fire;
    logic     out_free;

    imm_decode_comb #(.XLEN(XLEN)) u_dec (
        .inst (bus.inst),
        .res  (dec)
    );

    assign in_fire  = bus.in_valid && !skid_v;
    // OUT can take new data when it is empty or being consumed this edge.
    assign out_free = !out_v || bus.out_ready;

    // SKID only fills while OUT is stalled, so in_ready is blocked whenever it
    // holds data and SKID never needs to refill on the edge it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_r  <= '0;
            skid_r <= '0;
        end else if (out_free) begin
            if (skid_v) begin
                out_r  <= skid_r;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (in_fire) begin
                out_r <= dec;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (in_fire) begin
            skid_r <= dec;
            skid_v <= 1'b1;
        end
    end

    logic [IMM_MAX_W-1:0] imm_full;
    logic                 unused_imm_bits;

    assign imm_full        = out_r.imm;
    assign unused_imm_bits = ^imm_full;

    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = out_v;
    assign bus.imm_val   = imm_full[XLEN-1:0];
    assign bus.fmt       = out_r.fmt;
    assign bus.illegal   = out_r.illegal;

`ifdef IMM_GEN_PIPE_STATS_EN
    logic [15:0] illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (stat_clr) begin
            illegal_cnt <= '0;
        end else if (out_v && bus.out_ready && out_r.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end

    assign stat_illegal_cnt = illegal_cnt;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Both instances receive identical stimulus; each is checked against its own
// expected values. Honours IMM_GEN_PIPE_STATS_EN.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

`ifdef IMM_GEN_PIPE_STATS_EN
    logic        stat_clr;
    logic [15:0] cnt32;
    logic [15:0] cnt64;
`endif

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus32)
`ifdef IMM_GEN_PIPE_STATS_EN
        ,
        .stat_clr         (stat_clr),
        .stat_illegal_cnt (cnt32)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus64)
`ifdef IMM_GEN_PIPE_STATS_EN
        ,
        .stat_clr         (stat_clr),
        .stat_illegal_cnt (cnt64)
`endif
    );

    task automatic drive(input logic v, input logic [31:0] i, input logic ordy);
        bus32.in_valid = v; bus32.inst = i; bus32.out_ready = ordy;
        bus64.in_valid = v; bus64.inst = i; bus64.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder built on signed shifts of the whole word.
    function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                    output logic [63:0] imm, output imm_fmt_e f,
                                    output logic ill);
        int si;
        int t;
        si  = i;
        t   = 0;
        f   = FMT_NONE;
        ill = 1'b0;
        case (i[6:0])
            7'b0000011, 7'b1100111: begin t = si >>> 20; f = FMT_I; end
            7'b0010011: begin
                if (i[13:12] == 2'b01) begin
                    t = (xlen == 64) ? int'(i[25:20]) : int'(i[24:20]);
                    f = FMT_SHAMT;
                end else begin
                    t = si >>> 20; f = FMT_I;
                end
            end
            7'b0100011: begin
                t = si >>> 20;
                t = (t & ~32'h1F) | int'(i[11:7]);
                f = FMT_S;
            end
            7'b1100011: begin
                t = si >>> 20;
                t = (t & ~32'h81F) | (int'(i[7]) << 11) | (int'(i[11:8]) << 1);
                f = FMT_B;
            end
            7'b0110111, 7'b0010111: begin t = si & ~32'hFFF; f = FMT_U; end
            7'b1101111: begin
                t = si >>> 11;
                t = (t & ~32'hFFFFF) | (si & 32'h000FF000) | (int'(i[20]) << 11)
                    | (int'(i[30:21]) << 1);
                f = FMT_J;
            end
            default: ill = 1'b1;
        endcase
        imm = longint'(t);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
`ifdef IMM_GEN_PIPE_STATS_EN
        stat_clr = 1'b0;
`endif
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid32 got %b want 0", bus32.out_valid); end
        n_cmp++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready32 got %b want 1", bus32.in_ready); end
        n_cmp++; if (bus32.imm_val !== 32'h0) begin n_fail++; $display("FAIL rst_imm32 got %h want 0", bus32.imm_val); end
        n_cmp++; if (bus32.fmt !== FMT_NONE) begin n_fail++; $display("FAIL rst_fmt32 got %0d want 0", bus32.fmt); end
        n_cmp++; if (bus32.illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal32 got %b want 0", bus32.illegal); end
        n_cmp++; if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid64 got %b want 0", bus64.out_valid); end
        n_cmp++; if (bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready64 got %b want 1", bus64.in_ready); end
        n_cmp++; if (bus64.imm_val !== 64'h0) begin n_fail++; $display("FAIL rst_imm64 got %h want 0", bus64.imm_val); end
        n_cmp++; if (bus64.fmt !== FMT_NONE) begin n_fail++; $display("FAIL rst_fmt64 got %0d want 0", bus64.fmt); end
        n_cmp++; if (bus64.illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal64 got %b want 0", bus64.illegal); end
`ifdef IMM_GEN_PIPE_STATS_EN
        n_cmp++; if (cnt32 !== 16'd0 || cnt64 !== 16'd0) begin n_fail++; $display("FAIL rst_stat got %0d/%0d want 0", cnt32, cnt64); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] vi  [12] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h800000B7,
                                  32'h03F09093, 32'hFFDFF06F, 32'hFFF03093, 32'h4030D093,
                                  32'h0000007F, 32'h00808067, 32'h12345097, 32'h80012083};
        logic [31:0] e32 [12] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h80000000,
                                  32'h0000001F, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000003,
                                  32'h00000000, 32'h00000008, 32'h12345000, 32'hFFFFF800};
        logic [63:0] e64 [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hC, 64'hFFFFFFFFFFFFFFFC,
                                  64'hFFFFFFFF80000000, 64'h3F, 64'hFFFFFFFFFFFFFFFC,
                                  64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h0, 64'h8,
                                  64'h12345000, 64'hFFFFFFFFFFFFF800};
        imm_fmt_e    ef  [12] = '{FMT_I, FMT_S, FMT_B, FMT_U, FMT_SHAMT, FMT_J,
                                  FMT_I, FMT_SHAMT, FMT_NONE, FMT_I, FMT_U, FMT_I};
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, vi[k], 1'b1);
            tick();
            n_cmp++;
            if (bus32.out_valid !== 1'b1 || bus32.imm_val !== e32[k] || bus32.fmt !== ef[k]
                || bus32.illegal !== (ef[k] == FMT_NONE)) begin
                n_fail++;
                $display("FAIL dec32[%0d] inst %h got v=%b imm=%h fmt=%0d ill=%b want v=1 imm=%h fmt=%0d",
                         k, vi[k], bus32.out_valid, bus32.imm_val, bus32.fmt, bus32.illegal, e32[k], ef[k]);
            end
            n_cmp++;
            if (bus64.out_valid !== 1'b1 || bus64.imm_val !== e64[k] || bus64.fmt !== ef[k]
                || bus64.illegal !== (ef[k] == FMT_NONE)) begin
                n_fail++;
                $display("FAIL dec64[%0d] inst %h got v=%b imm=%h fmt=%0d ill=%b want v=1 imm=%h fmt=%0d",
                         k, vi[k], bus64.out_valid, bus64.imm_val, bus64.fmt, bus64.illegal, e64[k], ef[k]);
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
    endtask

`ifdef IMM_GEN_PIPE_STATS_EN
    task automatic test_stats();
        n_cmp++; if (cnt32 !== 16'd1 || cnt64 !== 16'd1) begin n_fail++; $display("FAIL stat_after_illegal got %0d/%0d want 1", cnt32, cnt64); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_cmp++; if (cnt32 !== 16'd0 || cnt64 !== 16'd0) begin n_fail++; $display("FAIL stat_clr got %0d/%0d want 0", cnt32, cnt64); end
        drive(1'b1, 32'h0000007F, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_cmp++; if (cnt32 !== 16'd0 || cnt64 !== 16'd0) begin n_fail++; $display("FAIL stat_clr_priority got %0d/%0d want 0", cnt32, cnt64); end
        drive(1'b1, 32'h0000007F, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        tick();
        n_cmp++; if (cnt32 !== 16'd1 || cnt64 !== 16'd1) begin n_fail++; $display("FAIL stat_incr got %0d/%0d want 1", cnt32, cnt64); end
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] seq [4] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h800000B7};
        logic [31:0] x32 [4] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h80000000};
        logic [63:0] x64 [4] = '{64'hFFFFFFFFFFFFFFFF, 64'hC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000};
        imm_fmt_e    xf  [4] = '{FMT_I, FMT_S, FMT_B, FMT_U};
        int ptr;
        int got32;
        int got64;
        logic acc;
        n_cmp++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %b want 1", bus32.in_ready); end
        drive(1'b1, seq[0], 1'b0);
        tick();
        n_cmp++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first got rdy=%b v=%b want 1/1", bus32.in_ready, bus32.out_valid); end
        drive(1'b1, seq[1], 1'b0);
        tick();
        n_cmp++; if (bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_fall got %b/%b want 0", bus32.in_ready, bus64.in_ready); end
        drive(1'b1, seq[2], 1'b0);
        tick();
        n_cmp++;
        if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.imm_val !== x32[0]
            || bus64.imm_val !== x64[0]) begin
            n_fail++;
            $display("FAIL bp_full_hold got rdy=%b v=%b imm=%h/%h want 0/1 %h/%h",
                     bus32.in_ready, bus32.out_valid, bus32.imm_val, bus64.imm_val, x32[0], x64[0]);
        end
        tick();
        drive(1'b1, seq[2], 1'b1);
        ptr = 2; got32 = 0; got64 = 0;
        for (int s = 0; s < 10; s++) begin
            if (bus32.out_valid && bus32.out_ready) begin
                n_cmp++;
                if (got32 >= 4) begin
                    n_fail++; $display("FAIL bp_extra32 got extra output imm=%h want none", bus32.imm_val);
                end else if (bus32.imm_val !== x32[got32] || bus32.fmt !== xf[got32] || s != got32) begin
                    n_fail++;
                    $display("FAIL bp_order32[%0d] got imm=%h fmt=%0d slot=%0d want imm=%h fmt=%0d slot=%0d",
                             got32, bus32.imm_val, bus32.fmt, s, x32[got32], xf[got32], got32);
                end
                got32++;
            end
            if (bus64.out_valid && bus64.out_ready) begin
                n_cmp++;
                if (got64 >= 4) begin
                    n_fail++; $display("FAIL bp_extra64 got extra output imm=%h want none", bus64.imm_val);
                end else if (bus64.imm_val !== x64[got64] || bus64.fmt !== xf[got64] || s != got64) begin
                    n_fail++;
                    $display("FAIL bp_order64[%0d] got imm=%h fmt=%0d slot=%0d want imm=%h fmt=%0d slot=%0d",
                             got64, bus64.imm_val, bus64.fmt, s, x64[got64], xf[got64], got64);
                end
                got64++;
            end
            acc = bus32.in_valid && bus32.in_ready;
            tick();
            if (acc) begin
                ptr++;
                if (ptr < 4) drive(1'b1, seq[ptr], 1'b1);
                else drive(1'b0, 32'h0, 1'b1);
            end
        end
        n_cmp++; if (got32 != 4 || got64 != 4) begin n_fail++; $display("FAIL bp_count got %0d/%0d want 4", got32, got64); end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  pool [10] = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0010011, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
        logic [31:0] insts [100];
        logic [31:0] r;
        logic [63:0] e;
        imm_fmt_e    f;
        logic        il;
        int ptr;
        int got;
        int last;
        logic acc;
        for (int k = 0; k < 100; k++) begin
            r = $urandom();
            r[6:0] = pool[$urandom_range(0, 9)];
            insts[k] = r;
        end
        ptr = 0; got = 0; last = -1;
        drive(1'b1, insts[0], 1'b1);
        for (int s = 0; s < 110; s++) begin
            if (bus32.out_valid && got < 100) begin
                n_cmp++;
                ref_dec(insts[got], 32, e, f, il);
                if (bus32.imm_val !== e[31:0] || bus32.fmt !== f || bus32.illegal !== il) begin
                    n_fail++;
                    $display("FAIL b2b32[%0d] inst %h got imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d ill=%b",
                             got, insts[got], bus32.imm_val, bus32.fmt, bus32.illegal, e[31:0], f, il);
                end
                n_cmp++;
                ref_dec(insts[got], 64, e, f, il);
                if (bus64.out_valid !== 1'b1 || bus64.imm_val !== e || bus64.fmt !== f || bus64.illegal !== il) begin
                    n_fail++;
                    $display("FAIL b2b64[%0d] inst %h got v=%b imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d ill=%b",
                             got, insts[got], bus64.out_valid, bus64.imm_val, bus64.fmt, bus64.illegal, e, f, il);
                end
                got++;
                last = s;
            end
            acc = bus32.in_valid && bus32.in_ready;
            tick();
            if (acc) begin
                ptr++;
                if (ptr < 100) drive(1'b1, insts[ptr], 1'b1);
                else drive(1'b0, 32'h0, 1'b1);
            end
        end
        n_cmp++; if (got != 100 || last != 100) begin n_fail++; $display("FAIL b2b_rate got %0d outputs last slot %0d want 100 outputs last slot 100", got, last); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 32'hFFF00093, 1'b0);
        tick();
        drive(1'b1, 32'h00112623, 1'b0);
        tick();
        n_cmp++; if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got rdy=%b v=%b want 0/1", bus32.in_ready, bus32.out_valid); end
        #2;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        #1;
        n_cmp++; if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b/%b want 0", bus32.out_valid, bus64.out_valid); end
        n_cmp++; if (bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b/%b want 1", bus32.in_ready, bus64.in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'hFE000EE3, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (bus32.out_valid !== 1'b1 || bus32.imm_val !== 32'hFFFFFFFC || bus64.imm_val !== 64'hFFFFFFFFFFFFFFFC
            || bus32.fmt !== FMT_B) begin
            n_fail++;
            $display("FAIL mid_after got v=%b imm=%h/%h fmt=%0d want 1 fffffffc/fffffffffffffffc 3",
                     bus32.out_valid, bus32.imm_val, bus64.imm_val, bus32.fmt);
        end
        tick();
        n_cmp++; if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale got %b/%b want 0", bus32.out_valid, bus64.out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
`ifdef IMM_GEN_PIPE_STATS_EN
        test_stats();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish want finish before 1000000");
        $fatal(1, "timeout");
    end
endmodule
